// File: rtl/fx3_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fx3_pkg
// Purpose  : Shared constants and state encoding for the FX3 GPIF write path.
// Revision : 1.0 - initial release
// ============================================================================
package fx3_pkg;

    localparam int FX3_DATA_WIDTH   = 32;
    localparam int FX3_PACKET_WORDS = 128;

    typedef logic [1:0] fx3_state_t;

    localparam fx3_state_t ST_IDLE     = 2'd0;
    localparam fx3_state_t ST_WAIT_RDY = 2'd1;
    localparam fx3_state_t ST_WRITE    = 2'd2;
    localparam fx3_state_t ST_GAP      = 2'd3;

endpackage
`default_nettype wire

// File: rtl/fx3_out_path.sv
`default_nettype none
// ============================================================================
// Module   : fx3_out_path
// Purpose  : FPGA-to-MCU GPIF write stage; splits a transfer into USB packets,
//            ends a trailing short packet with pkt_end, waits for channel ready.
// Revision : 1.0 - initial release
// ============================================================================
module fx3_out_path
    import fx3_pkg::*;
#(
    parameter int DATA_WIDTH   = FX3_DATA_WIDTH,
    parameter int PACKET_WORDS = FX3_PACKET_WORDS,
    parameter int SIZE_WIDTH   = 24,
    parameter int FLAG_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [SIZE_WIDTH-1:0] i_size,
    output logic                  o_busy,
    output logic                  o_done,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_fpga2mcu_ch_rdy,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_data_oe,
    output logic                  o_wr_n,
    output logic                  o_pkt_end_n
);

    localparam logic [SIZE_WIDTH-1:0] c_pkt_words = SIZE_WIDTH'(PACKET_WORDS);
    localparam logic [SIZE_WIDTH-1:0] c_flag_lat  = SIZE_WIDTH'(FLAG_LATENCY);
    localparam logic [SIZE_WIDTH-1:0] c_one       = SIZE_WIDTH'(1);

    fx3_state_t            r_state;
    fx3_state_t            w_state_nxt;
    logic [SIZE_WIDTH-1:0] r_remaining;
    logic [SIZE_WIDTH-1:0] r_pkt_cnt;
    logic [SIZE_WIDTH-1:0] w_pkt_load;
    logic                  r_short;
    logic                  w_ready;
    logic                  w_take;
    logic                  w_cnt_last;

    logic                  r_busy;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_data_oe;
    logic                  r_wr_n;
    logic                  r_pkt_end_n;

    assign w_take     = w_ready && i_valid;
    assign w_cnt_last = (r_pkt_cnt == c_one);
    assign w_pkt_load = (r_remaining < c_pkt_words) ? r_remaining : c_pkt_words;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start && (i_size != '0)) begin
                    w_state_nxt = ST_WAIT_RDY;
                end
            end
            ST_WAIT_RDY: begin
                if (i_fpga2mcu_ch_rdy) begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (w_take && w_cnt_last) begin
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_cnt_last) begin
                    w_state_nxt = (r_remaining != '0) ? ST_WAIT_RDY : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ready = 1'b0;
        if ((r_state == ST_WRITE) && (r_pkt_cnt != '0)) begin
            w_ready = 1'b1;
        end
    end

    // pkt_cnt counts words in WRITE and doubles as the flag-settle timer in GAP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_remaining <= '0;
            r_pkt_cnt   <= '0;
            r_short     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_data      <= '0;
            r_data_oe   <= 1'b0;
            r_wr_n      <= 1'b1;
            r_pkt_end_n <= 1'b1;
        end else begin
            r_done      <= 1'b0;
            r_wr_n      <= 1'b1;
            r_pkt_end_n <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (i_size != '0) begin
                            r_remaining <= i_size;
                            r_busy      <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_WAIT_RDY: begin
                    if (i_fpga2mcu_ch_rdy) begin
                        r_pkt_cnt <= w_pkt_load;
                        r_short   <= (r_remaining < c_pkt_words);
                        r_data_oe <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (w_take) begin
                        r_data      <= i_data;
                        r_wr_n      <= 1'b0;
                        r_remaining <= r_remaining - c_one;
                        r_pkt_cnt   <= r_pkt_cnt - c_one;
                        if (w_cnt_last) begin
                            r_pkt_end_n <= !r_short;
                            r_pkt_cnt   <= c_flag_lat;
                        end
                    end
                end
                ST_GAP: begin
                    r_pkt_cnt <= r_pkt_cnt - c_one;
                    if (w_cnt_last && (r_remaining == '0)) begin
                        r_data_oe <= 1'b0;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                    end
                end
                default: begin
                    r_pkt_cnt <= '0;
                end
            endcase
        end
    end

    assign o_ready     = w_ready;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_data      = r_data;
    assign o_data_oe   = r_data_oe;
    assign o_wr_n      = r_wr_n;
    assign o_pkt_end_n = r_pkt_end_n;

endmodule
`default_nettype wire

// File: tb/tb_fx3_out_path.sv
`default_nettype none
// ============================================================================
// Module   : tb_fx3_out_path
// Purpose  : Scoreboard bench for fx3_out_path: expected GPIF writes are queued
//            at stimulus time and checked by an independent write monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fx3_out_path;

    localparam int DW  = 32;
    localparam int PW  = 128;
    localparam int SW  = 24;
    localparam int FL  = 3;

    typedef struct {
        logic [DW-1:0] data;
        logic          pend;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          i_start;
    logic [SW-1:0] i_size;
    logic          o_busy;
    logic          o_done;
    logic [DW-1:0] i_data;
    logic          i_valid;
    logic          o_ready;
    logic          i_fpga2mcu_ch_rdy;
    logic [DW-1:0] o_data;
    logic          o_data_oe;
    logic          o_wr_n;
    logic          o_pkt_end_n;

    fx3_out_path #(
        .DATA_WIDTH  (DW),
        .PACKET_WORDS(PW),
        .SIZE_WIDTH  (SW),
        .FLAG_LATENCY(FL)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_start          (i_start),
        .i_size           (i_size),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .i_data           (i_data),
        .i_valid          (i_valid),
        .o_ready          (o_ready),
        .i_fpga2mcu_ch_rdy(i_fpga2mcu_ch_rdy),
        .o_data           (o_data),
        .o_data_oe        (o_data_oe),
        .o_wr_n           (o_wr_n),
        .o_pkt_end_n      (o_pkt_end_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    int   wr_cycles[$];
    int   pend_count, done_count, done_cyc, busy_seen, oe_seen, start_cyc;
    exp_t mon_e;

    int            feed_total  = 0;
    int            feed_idx    = 0;
    logic [DW-1:0] feed_base   = '0;
    bit            feed_toggle = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name, input longint act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %0d, required no such event", name, act);
    endtask

    // Upstream source: offers base+idx, optionally only on alternate cycles.
    initial begin : feeder
        bit took;
        bit phase;
        phase   = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        forever begin
            @(negedge clk);
            took = o_ready && i_valid;
            @(posedge clk);
            #1;
            if (took) feed_idx++;
            phase = ~phase;
            if ((feed_idx < feed_total) && (!feed_toggle || phase)) begin
                i_valid = 1'b1;
                i_data  = feed_base + DW'(feed_idx);
            end else begin
                i_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!o_wr_n) begin
            wr_cycles.push_back(cyc);
            if (!o_pkt_end_n) pend_count++;
            if (exp_q.size() == 0) begin
                flag_fail("unexpected_write", longint'(o_data));
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_data", longint'(o_data), longint'(mon_e.data));
                check("wr_pkt_end_n", longint'(o_pkt_end_n), longint'(!mon_e.pend));
            end
        end else if (!o_pkt_end_n) begin
            flag_fail("pkt_end_without_write", longint'(cyc));
        end
        if (o_done) begin
            done_count++;
            done_cyc = cyc;
        end
        if (o_busy) busy_seen++;
        if (o_data_oe) oe_seen++;
    end

    task automatic start_xfer(input int size, input logic [DW-1:0] base, input bit toggle);
        exp_t e;
        for (int k = 0; k < size; k++) begin
            e.data = base + DW'(k);
            e.pend = (k == size - 1) && ((size % PW) != 0);
            exp_q.push_back(e);
        end
        wr_cycles.delete();
        pend_count  = 0;
        done_count  = 0;
        busy_seen   = 0;
        oe_seen     = 0;
        feed_base   = base;
        feed_idx    = 0;
        feed_total  = size;
        feed_toggle = toggle;
        @(negedge clk);
        i_start   = 1'b1;
        i_size    = SW'(size);
        start_cyc = cyc;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_count > 0) return;
            @(negedge clk);
            #1;
        end
        if (done_count == 0) flag_fail({name, "_done_timeout"}, longint'(budget));
    endtask

    function automatic int last_wr();
        return (wr_cycles.size() == 0) ? -1 : wr_cycles[wr_cycles.size() - 1];
    endfunction

    initial begin : stimulus
        int seg[$];
        int len;
        int min_diff;
        int viol;
        int rdy_cyc;

        rst               = 1'b0;
        i_start           = 1'b0;
        i_size            = '0;
        i_fpga2mcu_ch_rdy = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_busy",      longint'(o_busy),      0);
        check("rst_done",      longint'(o_done),      0);
        check("rst_ready",     longint'(o_ready),     0);
        check("rst_wr_n",      longint'(o_wr_n),      1);
        check("rst_pkt_end_n", longint'(o_pkt_end_n), 1);
        check("rst_data_oe",   longint'(o_data_oe),   0);
        check("rst_data",      longint'(o_data),      0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // One full packet: no pkt_end, done three cycles after the final write.
        start_xfer(128, 32'd0, 1'b0);
        check("t1_busy_after_start", longint'(o_busy), 1);
        wait_done("t1", 2000);
        repeat (5) @(negedge clk);
        check("t1_writes",     wr_cycles.size(), 128);
        check("t1_pkt_ends",   pend_count, 0);
        check("t1_done_count", done_count, 1);
        check("t1_done_delay", done_cyc - last_wr(), FL);
        check("t1_queue_left", exp_q.size(), 0);
        check("t1_busy_end",   longint'(o_busy), 0);
        check("t1_oe_end",     longint'(o_data_oe), 0);

        // 128+128+44; between packets: FL gap cycles, one WAIT_RDY, one consume.
        start_xfer(300, 32'd1000, 1'b0);
        wait_done("t2", 3000);
        repeat (5) @(negedge clk);
        seg.delete();
        len = 1;
        for (int i = 1; i < wr_cycles.size(); i++) begin
            if (wr_cycles[i] - wr_cycles[i-1] == 1) begin
                len++;
            end else begin
                seg.push_back(len);
                check("t2_gap", wr_cycles[i] - wr_cycles[i-1], FL + 2);
                len = 1;
            end
        end
        if (wr_cycles.size() != 0) seg.push_back(len);
        check("t2_writes",    wr_cycles.size(), 300);
        check("t2_segments",  seg.size(), 3);
        if (seg.size() == 3) begin
            check("t2_seg0", seg[0], 128);
            check("t2_seg1", seg[1], 128);
            check("t2_seg2", seg[2], 44);
        end
        check("t2_pkt_ends",   pend_count, 1);
        check("t2_done_count", done_count, 1);
        check("t2_queue_left", exp_q.size(), 0);

        // Stalling upstream: valid on alternate cycles only.
        start_xfer(5, 32'hA000_0000, 1'b1);
        wait_done("t3", 200);
        repeat (5) @(negedge clk);
        min_diff = 1000;
        for (int i = 1; i < wr_cycles.size(); i++) begin
            if (wr_cycles[i] - wr_cycles[i-1] < min_diff) min_diff = wr_cycles[i] - wr_cycles[i-1];
        end
        check("t3_writes",      wr_cycles.size(), 5);
        check("t3_min_spacing", (min_diff >= 2) ? 1 : 0, 1);
        check("t3_pkt_ends",    pend_count, 1);
        check("t3_queue_left",  exp_q.size(), 0);

        // Channel not ready for 20 cycles after start.
        i_fpga2mcu_ch_rdy = 1'b0;
        start_xfer(10, 32'h0000_9000, 1'b0);
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (o_ready || !o_wr_n) viol++;
        end
        check("t4_wait_quiet", viol, 0);
        check("t4_wait_busy",  longint'(o_busy), 1);
        @(negedge clk);
        i_fpga2mcu_ch_rdy = 1'b1;
        rdy_cyc = cyc;
        wait_done("t4", 200);
        repeat (5) @(negedge clk);
        check("t4_first_write_lat", (wr_cycles.size() > 0) ? wr_cycles[0] - rdy_cyc : -1, 2);
        check("t4_writes",     wr_cycles.size(), 10);
        check("t4_queue_left", exp_q.size(), 0);

        // Zero-length transfer.
        start_xfer(0, 32'd0, 1'b0);
        wait_done("t5", 20);
        repeat (5) @(negedge clk);
        check("t5_done_delay", done_cyc - start_cyc, 1);
        check("t5_done_count", done_count, 1);
        check("t5_busy_seen",  busy_seen, 0);
        check("t5_oe_seen",    oe_seen, 0);
        check("t5_writes",     wr_cycles.size(), 0);

        // Asynchronous reset at write 50, then a clean short transfer.
        start_xfer(200, 32'h0000_5000, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            if (wr_cycles.size() >= 50) break;
            @(negedge clk);
            #1;
        end
        check("t6_reached_50", (wr_cycles.size() >= 50) ? 1 : 0, 1);
        rst = 1'b0;
        #1;
        check("t6_rst_wr_n",  longint'(o_wr_n), 1);
        check("t6_rst_oe",    longint'(o_data_oe), 0);
        check("t6_rst_busy",  longint'(o_busy), 0);
        check("t6_rst_ready", longint'(o_ready), 0);
        exp_q.delete();
        feed_total = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        start_xfer(3, 32'h0000_7000, 1'b0);
        wait_done("t6", 200);
        repeat (5) @(negedge clk);
        check("t6_writes",     wr_cycles.size(), 3);
        check("t6_pkt_ends",   pend_count, 1);
        check("t6_done_count", done_count, 1);
        check("t6_queue_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
